vpa_gen: RTL and testbench
==========================

# vpa_gen

Upstream companion to the 6800-cycle emulator. Watches the accelerator CPU's address strobe, function codes and upper address bits, then decides whether the current bus cycle is a synchronous (6800-style) cycle. It drives VPA_n and CPUSPACE into the emulator, which answers with VMA_n and M6800_DTACK_n. It also raises a bus error if the emulated cycle never completes. It runs on the same C7M clock as the emulator.

## Interface
Parameters:
- CIA_BASE, 8'hBF, value of A[23:16] that selects the CIA window.
- TIMEOUT_CYCLES, 40, number of C7M cycles allowed from VPA_n assertion to M6800_DTACK_n low. Legal range is 2..255.

Ports:
- C7M  in  1  system clock; all state updates on posedge.
- RESET_n  in  1  reset, asynchronous, active-low.
- AS_CPU_n  in  1  CPU address strobe; asynchronous to C7M.
- FC  in  3  CPU function codes; stable while AS_CPU_n is low.
- A  in  8  CPU address bits A[23:16]; stable while AS_CPU_n is low.
- M6800_DTACK_n  in  1  completion from the emulator; C7M domain, no synchroniser.
- VPA_n  out  1  valid peripheral address to CPU and emulator. Reset value 1.
- CPUSPACE  out  1  registered (FC == 3'b111) for the current cycle. Reset value 0.
- BERR_n  out  1  bus error to CPU. Reset value 1.

## Operation
- AS_CPU_n passes through a 2-FF synchroniser (as_s). Both flops reset to 1.
- State machine states: IDLE, DECODE, ACTIVE, PASS, ERROR. Reset state is IDLE.
- IDLE
  - When as_s == 0: latch FC and A into fc_q and a_q.
  - Set CPUSPACE to (FC == 7).
  - Go to DECODE.
- DECODE
  - cia_hit = (fc_q != 7) && (a_q == CIA_BASE).
  - iack_hit = (fc_q == 7) && (a_q[3:0] == 4'hF).
  - On a hit: vpa_q <= 0, counter <= 0, go to ACTIVE. Otherwise go to PASS.
- ACTIVE
  - If M6800_DTACK_n == 0, freeze the counter and hold.
  - Otherwise increment the counter. The counter saturates and is $clog2(TIMEOUT_CYCLES+1) bits wide.
  - When the counter reaches TIMEOUT_CYCLES-1 with M6800_DTACK_n still high: vpa_q <= 1, BERR_n <= 0, go to ERROR.
- PASS: not a synchronous cycle; outputs stay inactive.
- ERROR: hold BERR_n = 0.
- Any state except IDLE, when as_s == 1:
  - vpa_q <= 1, BERR_n <= 1, CPUSPACE <= 0.
  - Counter <= 0, go to IDLE.
  - This check has priority over every other transition in the same cycle.
- VPA_n = vpa_q | AS_CPU_n. The raw strobe gives an immediate combinational release, so VPA_n can never carry over into the next CPU cycle.
- Reset mid-cycle forces all outputs to their reset values immediately and sends the FSM to IDLE.

## Timing
- Falling edge of AS_CPU_n to VPA_n low:
  - 3 posedges of C7M (sync, sync, DECODE), plus 1 more if AS falls inside the setup window.
  - In general, VPA_n falls on the posedge that DECODE executes.
- Rising edge of AS_CPU_n to VPA_n high: 0 cycles (combinational).
- Rising edge of AS_CPU_n to BERR_n high and CPUSPACE low: 2 posedges, through the synchroniser.
- Timeout: BERR_n falls exactly TIMEOUT_CYCLES posedges after the posedge on which VPA_n fell, provided M6800_DTACK_n stays high throughout.
- M6800_DTACK_n falling on the same posedge the counter hits its limit: DTACK wins. No BERR_n is raised.
- Back-to-back CPU cycles: a new AS low is only accepted from IDLE. The minimum AS-high time the FSM handles without missing a cycle is 3 C7M periods.

## Configuration
- VPA_GEN_AUTOVECTOR_EN
  - Defined: iack_hit claims interrupt-acknowledge cycles with VPA_n, giving the CPU an autovector.
  - Undefined: iack_hit is tied to 0, so IACK cycles go to PASS and VPA_n stays high. CPUSPACE is still produced in both builds.

## Test plan
- Reset with AS_CPU_n = 0 -> VPA_n = 1, BERR_n = 1, CPUSPACE = 0. FSM enters DECODE only after release and 2 sync cycles.
- FC = 5, A = 8'hBF, AS low; M6800_DTACK_n low 12 cycles later -> VPA_n low 3 cycles after AS. BERR_n stays 1. On AS high, VPA_n goes high the same cycle.
- FC = 5, A = 8'hC0 -> VPA_n stays 1 for the whole cycle; FSM visits PASS.
- FC = 7, A = 8'hFF, with VPA_GEN_AUTOVECTOR_EN -> CPUSPACE = 1 and VPA_n = 0. Without the macro -> CPUSPACE = 1 and VPA_n = 1.
- CIA hit, M6800_DTACK_n held high -> BERR_n low exactly 40 cycles after VPA_n falls, with VPA_n high from the same edge. BERR_n clears 2 cycles after AS rises.
- CIA hit, M6800_DTACK_n falls on cycle 39 -> no BERR_n is asserted.

Source files
------------

// File: rtl/vpa_gen.sv
// vpa_gen: decides whether the current CPU bus cycle is a synchronous (6800-style) cycle.
// Drives VPA_n and CPUSPACE to the 6800-cycle emulator and raises BERR_n when the
// emulated cycle does not complete within TIMEOUT_CYCLES C7M periods.
// Optional build macro: VPA_GEN_AUTOVECTOR_EN - claim IACK cycles with VPA_n (autovector).
module vpa_gen #(
  parameter logic [7:0]  CIA_BASE       = 8'hBF,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic       C7M,
  input  logic       RESET_n,
  input  logic       AS_CPU_n,
  input  logic [2:0] FC,
  input  logic [7:0] A,
  input  logic       M6800_DTACK_n,
  output logic       VPA_n,
  output logic       CPUSPACE,
  output logic       BERR_n
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StActive = 3'd2;
  localparam logic [2:0] StPass   = 3'd3;
  localparam logic [2:0] StError  = 3'd4;

  logic [1:0]      as_sync_q;
  logic            as_s;
  logic            as_rel;
  logic [2:0]      state_q, state_d;
  logic [2:0]      fc_q, fc_d;
  logic [7:0]      a_q, a_d;
  logic            vpa_q, vpa_d;
  logic            berr_q, berr_d;
  logic            cs_q, cs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cia_hit;
  logic            iack_hit;

  // Two-stage synchroniser for the asynchronous address strobe.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      as_sync_q <= 2'b11;
    end else begin
      as_sync_q <= {as_sync_q[0], AS_CPU_n};
    end
  end

  // The FSM register is the capture stage after the first flop, so the strobe reaches a
  // decision two edges after it moves. The second flop stretches the release so a strobe
  // that was high for only one sample still terminates the cycle.
  assign as_s   = as_sync_q[0];
  assign as_rel = as_sync_q[0] | as_sync_q[1];

  assign cia_hit = (fc_q != 3'd7) && (a_q == CIA_BASE);
`ifdef VPA_GEN_AUTOVECTOR_EN
  assign iack_hit = (fc_q == 3'd7) && (a_q[3:0] == 4'hF);
`else
  assign iack_hit = 1'b0;
`endif

  // Next-state logic; a released strobe overrides every other transition.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    a_d     = a_q;
    vpa_d   = vpa_q;
    berr_d  = berr_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    if ((state_q != StIdle) && as_rel) begin
      vpa_d   = 1'b1;
      berr_d  = 1'b1;
      cs_d    = 1'b0;
      cnt_d   = '0;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (!as_s) begin
            fc_d    = FC;
            a_d     = A;
            cs_d    = (FC == 3'd7);
            state_d = StDecode;
          end
        end
        StDecode: begin
          if (cia_hit || iack_hit) begin
            vpa_d   = 1'b0;
            cnt_d   = '0;
            state_d = StActive;
          end else begin
            state_d = StPass;
          end
        end
        StActive: begin
          // A low DTACK freezes the count, so it wins even on the limit edge.
          if (M6800_DTACK_n) begin
            if (cnt_q == CntLast) begin
              vpa_d   = 1'b1;
              berr_d  = 1'b0;
              state_d = StError;
            end else if (cnt_q != CntMax) begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StPass:  ;
        StError: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= StIdle;
      fc_q    <= 3'd0;
      a_q     <= 8'd0;
      vpa_q   <= 1'b1;
      berr_q  <= 1'b1;
      cs_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      a_q     <= a_d;
      vpa_q   <= vpa_d;
      berr_q  <= berr_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
    end
  end

  // Raw strobe gives an immediate release at the end of the CPU cycle.
  assign VPA_n    = vpa_q | AS_CPU_n;
  assign BERR_n   = berr_q;
  assign CPUSPACE = cs_q;

endmodule

// File: tb/tb_vpa_gen.sv
// Self-checking bench for vpa_gen: table vectors, hand-written corner sequences and
// randomized bus cycles checked edge by edge against a window-based reference model.
module tb_vpa_gen;

  localparam int T = 40;
`ifdef VPA_GEN_AUTOVECTOR_EN
  localparam bit AV = 1'b1;
`else
  localparam bit AV = 1'b0;
`endif

  logic       C7M;
  logic       RESET_n;
  logic       AS_CPU_n;
  logic [2:0] FC;
  logic [7:0] A;
  logic       M6800_DTACK_n;
  logic       VPA_n;
  logic       CPUSPACE;
  logic       BERR_n;

  int n_checks;
  int n_fail;

  vpa_gen #(
    .CIA_BASE       (8'hBF),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .C7M           (C7M),
    .RESET_n       (RESET_n),
    .AS_CPU_n      (AS_CPU_n),
    .FC            (FC),
    .A             (A),
    .M6800_DTACK_n (M6800_DTACK_n),
    .VPA_n         (VPA_n),
    .CPUSPACE      (CPUSPACE),
    .BERR_n        (BERR_n)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model. Edge k is the k-th posedge after AS_CPU_n falls (driven on the
  // preceding negedge); AS is low for edges 1..h. The cycle is seen by the control
  // logic on edges 2..h+1, VPA may be driven from edge 3, and an undisturbed timeout
  // lands T edges after that. DTACK is low from edge d (0 = never).
  function automatic logic [2:0] model(input logic [2:0] fc, input logic [7:0] a,
                                       input int h, input int d, input int k);
    bit hit, alive, tmo, berr_low, vpa_low;
    hit      = ((fc != 3'd7) && (a == 8'hBF)) || (AV && (fc == 3'd7) && (a[3:0] == 4'hF));
    alive    = (k >= 2) && (k <= h + 1);
    tmo      = hit && ((d == 0) || (d > 3 + T));
    berr_low = tmo && (k >= 3 + T) && (k <= h + 1);
    vpa_low  = hit && (k >= 3) && (k <= h) && !(tmo && (k >= 3 + T));
    return {~vpa_low, ~berr_low, alive && (fc == 3'd7)};
  endfunction

  // One CPU bus cycle followed by an idle gap; checks every edge against the model.
  task automatic run_txn(input logic [2:0] fc, input logic [7:0] a, input int h,
                         input int d, output int vfall, output int bfall,
                         output bit any_cs);
    logic [2:0] e;
    vfall  = 0;
    bfall  = 0;
    any_cs = 1'b0;
    for (int k = 1; k <= h + 3; k++) begin
      @(negedge C7M);
      FC            = fc;
      A             = a;
      AS_CPU_n      = (k <= h) ? 1'b0 : 1'b1;
      M6800_DTACK_n = ((d != 0) && (k >= d) && (k <= h + 1)) ? 1'b0 : 1'b1;
      if (k == h + 1) begin
        #1;
        check("vpa_release_comb", int'(VPA_n), 1);
      end
      @(posedge C7M);
      #1;
      e = model(fc, a, h, d, k);
      check("vpa_n", int'(VPA_n), int'(e[2]));
      check("berr_n", int'(BERR_n), int'(e[1]));
      check("cpuspace", int'(CPUSPACE), int'(e[0]));
      if (VPA_n == 1'b0 && vfall == 0) vfall = k;
      if (BERR_n == 1'b0 && bfall == 0) bfall = k;
      if (CPUSPACE) any_cs = 1'b1;
    end
    repeat (2) @(negedge C7M);
  endtask

  typedef struct {
    logic [2:0] fc;
    logic [7:0] a;
    int         hold;
    int         dtack;
    int         exp_vfall;
    int         exp_bfall;
    bit         exp_cs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int vf, bf;
    bit cs;
    logic [2:0] e;
    int av3;
    n_checks      = 0;
    n_fail        = 0;
    av3           = AV ? 3 : 0;

    // Reset with AS already low: outputs inactive, cycle starts only after release.
    RESET_n       = 1'b0;
    AS_CPU_n      = 1'b0;
    FC            = 3'd5;
    A             = 8'hBF;
    M6800_DTACK_n = 1'b1;
    repeat (3) @(posedge C7M);
    #1;
    check("rst_vpa_n", int'(VPA_n), 1);
    check("rst_berr_n", int'(BERR_n), 1);
    check("rst_cpuspace", int'(CPUSPACE), 0);
    @(negedge C7M);
    RESET_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge C7M);
      #1;
      check("rst_release_vpa", int'(VPA_n), (k >= 3) ? 0 : 1);
    end
    @(negedge C7M);
    AS_CPU_n = 1'b1;
    #1;
    check("rst_release_comb", int'(VPA_n), 1);
    repeat (4) @(negedge C7M);

    // Table vectors: {fc, a, hold, dtack edge, first VPA low edge, first BERR low edge, cs}.
    vecs.push_back('{3'd5, 8'hBF, 20, 15, 3, 0, 1'b0});   // CIA hit, DTACK 12 later
    vecs.push_back('{3'd5, 8'hC0, 10, 0, 0, 0, 1'b0});    // miss -> PASS
    vecs.push_back('{3'd7, 8'hFF, 10, 5, av3, 0, 1'b1});  // IACK
    vecs.push_back('{3'd5, 8'hBF, 50, 0, 3, 3 + T, 1'b0}); // timeout
    vecs.push_back('{3'd5, 8'hBF, 50, 3 + T, 3, 0, 1'b0}); // DTACK on limit edge
    vecs.push_back('{3'd5, 8'hBF, 50, 4 + T, 3, 3 + T, 1'b0}); // DTACK one late
    vecs.push_back('{3'd7, 8'hBF, 8, 0, av3, 0, 1'b1});   // space 7 never a CIA hit
    vecs.push_back('{3'd7, 8'hF0, 8, 0, 0, 0, 1'b1});     // IACK nibble miss
    vecs.push_back('{3'd1, 8'hBF, 1, 0, 0, 0, 1'b0});     // AS too short for VPA
    vecs.push_back('{3'd5, 8'hBF, 2, 0, 0, 0, 1'b0});     // released before VPA edge
    foreach (vecs[i]) begin
      run_txn(vecs[i].fc, vecs[i].a, vecs[i].hold, vecs[i].dtack, vf, bf, cs);
      check($sformatf("vec%0d_vfall", i), vf, vecs[i].exp_vfall);
      check($sformatf("vec%0d_bfall", i), bf, vecs[i].exp_bfall);
      check($sformatf("vec%0d_cs", i), int'(cs), int'(vecs[i].exp_cs));
    end

    // Timeout spacing: BERR_n falls exactly T edges after VPA_n fell.
    run_txn(3'd2, 8'hBF, 46, 0, vf, bf, cs);
    check("timeout_gap", bf - vf, T);

    // Reset in the middle of a timed-out cycle: outputs return immediately.
    @(negedge C7M);
    FC            = 3'd7;
    A             = 8'hCF;
    M6800_DTACK_n = 1'b1;
    AS_CPU_n      = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge C7M);
      #1;
      e = model(3'd7, 8'hCF, 100, 0, k);
      check("pre_rst_vpa_n", int'(VPA_n), int'(e[2]));
      check("pre_rst_berr_n", int'(BERR_n), int'(e[1]));
      check("pre_rst_cpuspace", int'(CPUSPACE), int'(e[0]));
    end
    #2;
    RESET_n = 1'b0;
    #1;
    check("mid_rst_vpa_n", int'(VPA_n), 1);
    check("mid_rst_berr_n", int'(BERR_n), 1);
    check("mid_rst_cpuspace", int'(CPUSPACE), 0);
    @(negedge C7M);
    AS_CPU_n = 1'b1;
    RESET_n  = 1'b1;
    repeat (4) @(negedge C7M);

    // Randomized cycles against the model.
    for (int n = 0; n < 25; n++) begin
      logic [2:0] rfc;
      logic [7:0] ra;
      int rh, rd;
      rfc = 3'($urandom_range(0, 7));
      ra  = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: ra = 8'hBF;
        1: begin rfc = 3'd7; ra[3:0] = 4'hF; end
        2: ;
        default: begin rfc = 3'($urandom_range(0, 6)); ra = 8'hBF; end
      endcase
      rh = $urandom_range(1, 55);
      rd = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, rh + 2);
      run_txn(rfc, ra, rh, rd, vf, bf, cs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
